// File: rtl/chip_test_sequencer.sv
// Start-driven sequencer for a per-chip tester: pulses Run, samples Done/RSLT,
// repeats ITERATIONS times, then reports. Optional WAIT watchdog: WATCHDOG_TIMEOUT_EN.
module chip_test_sequencer #(
  parameter int unsigned ITERATIONS  = 16,
  parameter int unsigned CNT_W       = 8
`ifdef WATCHDOG_TIMEOUT_EN
  ,parameter int unsigned TIMEOUT_CYC = 1000000
`endif
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             ChipDone,
  input  logic             ChipRslt,
  output logic             ChipRun,
  output logic             DispRslt,
  output logic             Busy,
  output logic             Pass,
  output logic             Fail,
  output logic [CNT_W-1:0] PassCnt,
  output logic [CNT_W-1:0] FailCnt,
  output logic             Timeout
);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP, S_REPORT} state_t;

  localparam int unsigned      IDX_W    = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ITERATIONS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
`ifdef WATCHDOG_TIMEOUT_EN
  localparam int unsigned      WD_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
`endif

  state_t             r_state, w_state_nx;
  logic [CNT_W-1:0]   r_pass_cnt, r_fail_cnt, w_pass_nx, w_fail_nx;
  logic [IDX_W-1:0]   r_idx, w_idx_nx;
  logic               r_start_q;
  logic               w_start_edge;
  logic               r_chip_run, r_disp, r_busy, r_pass, r_fail;
`ifdef WATCHDOG_TIMEOUT_EN
  logic               r_timeout, w_tout_nx;
  logic [WD_W-1:0]    r_wd_cnt, w_wd_nx;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign w_start_edge = Start & ~r_start_q;

  // Next-state and next-counter logic
  always_comb begin
    w_state_nx = r_state;
    w_pass_nx  = r_pass_cnt;
    w_fail_nx  = r_fail_cnt;
    w_idx_nx   = r_idx;
`ifdef WATCHDOG_TIMEOUT_EN
    w_tout_nx  = r_timeout;
    w_wd_nx    = r_wd_cnt;
`endif
    case (r_state)
      S_IDLE, S_REPORT: begin
        if (w_start_edge) begin
          w_pass_nx  = '0;
          w_fail_nx  = '0;
          w_idx_nx   = '0;
`ifdef WATCHDOG_TIMEOUT_EN
          w_tout_nx  = 1'b0;
`endif
          w_state_nx = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        w_state_nx = S_WAIT;
`ifdef WATCHDOG_TIMEOUT_EN
        w_wd_nx    = '0;
`endif
      end
      S_WAIT: begin
        if (ChipDone) begin
          if (ChipRslt) w_pass_nx = sat_inc(r_pass_cnt);
          else          w_fail_nx = sat_inc(r_fail_cnt);
          w_idx_nx   = r_idx + IDX_W'(1);
          w_state_nx = S_GAP;
        end
`ifdef WATCHDOG_TIMEOUT_EN
        // Done on the last allowed cycle wins over the timeout
        else if (r_wd_cnt == WD_LAST) begin
          w_fail_nx  = sat_inc(r_fail_cnt);
          w_tout_nx  = 1'b1;
          w_state_nx = S_REPORT;
        end else begin
          w_wd_nx    = r_wd_cnt + WD_W'(1);
        end
`endif
      end
      S_GAP: begin
        if (!ChipDone) w_state_nx = (r_idx == LAST_IDX) ? S_REPORT : S_LAUNCH;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= S_IDLE;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_idx      <= '0;
      r_start_q  <= 1'b0;
      r_chip_run <= 1'b0;
      r_disp     <= 1'b0;
      r_busy     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
`ifdef WATCHDOG_TIMEOUT_EN
      r_timeout  <= 1'b0;
      r_wd_cnt   <= '0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_pass_cnt <= w_pass_nx;
      r_fail_cnt <= w_fail_nx;
      r_idx      <= w_idx_nx;
      r_start_q  <= Start;
      r_chip_run <= (w_state_nx == S_LAUNCH);
      r_disp     <= (w_state_nx == S_REPORT);
      r_busy     <= (w_state_nx inside {S_LAUNCH, S_WAIT, S_GAP});
      r_pass     <= (w_state_nx == S_REPORT) && (w_fail_nx == '0);
      r_fail     <= (w_state_nx == S_REPORT) && (w_fail_nx != '0);
`ifdef WATCHDOG_TIMEOUT_EN
      r_timeout  <= w_tout_nx;
      r_wd_cnt   <= w_wd_nx;
`endif
    end
  end

  assign ChipRun  = r_chip_run;
  assign DispRslt = r_disp;
  assign Busy     = r_busy;
  assign Pass     = r_pass;
  assign Fail     = r_fail;
  assign PassCnt  = r_pass_cnt;
  assign FailCnt  = r_fail_cnt;
`ifdef WATCHDOG_TIMEOUT_EN
  assign Timeout  = r_timeout;
`else
  assign Timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Bench for chip_test_sequencer: acts as the chip tester, table-driven and random runs,
// reset and watchdog corner sequences.
module tb_chip_test_sequencer;

  localparam int ITER  = 16;
  localparam int CNT_W = 8;
  localparam int NV    = 6;

  logic             Clk, Reset, Start, ChipDone, ChipRslt;
  logic             ChipRun, DispRslt, Busy, Pass, Fail, Timeout;
  logic [CNT_W-1:0] PassCnt, FailCnt;

  chip_test_sequencer #(
    .ITERATIONS(ITER),
    .CNT_W(CNT_W)
`ifdef WATCHDOG_TIMEOUT_EN
    ,.TIMEOUT_CYC(8)
`endif
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .ChipDone(ChipDone), .ChipRslt(ChipRslt),
    .ChipRun(ChipRun), .DispRslt(DispRslt), .Busy(Busy), .Pass(Pass), .Fail(Fail),
    .PassCnt(PassCnt), .FailCnt(FailCnt), .Timeout(Timeout)
  );

  typedef struct {
    int dly;
    int hold;
    int bad_pass;
    bit noise;
    int exp_pcnt;
    int exp_fcnt;
    bit exp_pass;
    bit exp_fail;
  } vec_t;

  vec_t vecs [NV];
  int   p_dly  [ITER];
  int   p_hold [ITER];
  bit   p_rslt [ITER];
  int   n_vec, n_mis, run_pulses;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) if (ChipRun === 1'b1) run_pulses <= run_pulses + 1;

  initial begin
    #500000;
    $display("FAIL sim_time_limit: got still running, expected finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({ChipRun, DispRslt, Busy, Pass, Fail, Timeout, PassCnt, FailCnt});
  endfunction

  // Tester side of one pass; entered with ChipRun visible, leaves one edge after Done falls
  task automatic do_pass(input int dly, input int hold, input bit rslt, input bit noise);
    tick();
    chk("run_width", 32'(ChipRun), 32'd0);
    chk("busy", 32'(Busy), 32'd1);
    for (int i = 1; i < dly; i++) begin
      if (noise) Start = 1'($urandom);
      tick();
    end
    Start    = 1'b0;
    ChipDone = 1'b1;
    ChipRslt = rslt;
    repeat (hold) tick();
    chk("gap_run", 32'(ChipRun), 32'd0);
    ChipDone = 1'b0;
    ChipRslt = 1'($urandom);
    tick();
  endtask

  task automatic do_run(input bit noise, input int ep, input int ef, input bit epass,
                        input bit efail, input string tag);
    int base;
    base  = run_pulses;
    Start = 1'b1;
    tick();
    chk({tag, ".start_lat"}, 32'(ChipRun), 32'd1);
    chk({tag, ".clear"}, 32'({PassCnt, FailCnt}), 32'd0);
    Start = 1'b0;
    for (int p = 0; p < ITER; p++) begin
      do_pass(p_dly[p], p_hold[p], p_rslt[p], noise);
      if (p < ITER - 1) chk({tag, ".rerun_lat"}, 32'(ChipRun), 32'd1);
    end
    chk({tag, ".disp"}, 32'(DispRslt), 32'd1);
    chk({tag, ".busy_end"}, 32'(Busy), 32'd0);
    chk({tag, ".pcnt"}, 32'(PassCnt), 32'(ep));
    chk({tag, ".fcnt"}, 32'(FailCnt), 32'(ef));
    chk({tag, ".pass"}, 32'(Pass), 32'(epass));
    chk({tag, ".fail"}, 32'(Fail), 32'(efail));
    chk({tag, ".timeout"}, 32'(Timeout), 32'd0);
    repeat (3) tick();
    chk({tag, ".pulses"}, 32'(run_pulses - base), 32'(ITER));
    chk({tag, ".hold"}, 32'({DispRslt, PassCnt, FailCnt}), 32'({1'b1, 8'(ep), 8'(ef)}));
  endtask

  initial begin
    int ep;
    n_vec = 0; n_mis = 0; run_pulses = 0;
    Reset = 1'b0; Start = 1'b0; ChipDone = 1'b0; ChipRslt = 1'b0;

    vecs[0] = '{5, 1,  -1, 1'b0, 16, 0, 1'b1, 1'b0};
    vecs[1] = '{5, 1,   6, 1'b0, 15, 1, 1'b0, 1'b1};
    vecs[2] = '{2, 10, -1, 1'b0, 16, 0, 1'b1, 1'b0};
    vecs[3] = '{4, 2,  -1, 1'b1, 16, 0, 1'b1, 1'b0};
    vecs[4] = '{1, 3,   0, 1'b0, 15, 1, 1'b0, 1'b1};
    vecs[5] = '{8, 1,  15, 1'b1, 15, 1, 1'b0, 1'b1};

    repeat (3) tick();
    chk("reset_state", all_outs(), 32'd0);
    Reset = 1'b1;
    repeat (2) tick();
    chk("idle_state", all_outs(), 32'd0);

    for (int v = 0; v < NV; v++) begin
      for (int p = 0; p < ITER; p++) begin
        p_dly[p]  = vecs[v].dly;
        p_hold[p] = vecs[v].hold;
        p_rslt[p] = (p != vecs[v].bad_pass);
      end
      do_run(vecs[v].noise, vecs[v].exp_pcnt, vecs[v].exp_fcnt,
             vecs[v].exp_pass, vecs[v].exp_fail, $sformatf("vec%0d", v));
    end

    // Reset asserted mid-WAIT with three passes counted
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int p = 0; p < 3; p++) do_pass(2, 1, 1'b1, 1'b0);
    chk("pre_reset_pcnt", 32'(PassCnt), 32'd3);
    repeat (2) tick();
    Reset = 1'b0;
    #1;
    chk("reset_async", all_outs(), 32'd0);
    begin
      int base;
      base = run_pulses;
      repeat (3) tick();
      chk("reset_hold", all_outs(), 32'd0);
      chk("reset_no_run", 32'(run_pulses - base), 32'd0);
    end
    Reset = 1'b1;
    repeat (2) tick();
    for (int p = 0; p < ITER; p++) begin
      p_dly[p] = 3; p_hold[p] = 1; p_rslt[p] = 1'b1;
    end
    do_run(1'b0, ITER, 0, 1'b1, 1'b0, "post_reset");

    // Random tester timing and results against a counting model
    for (int r = 0; r < 6; r++) begin
      ep = 0;
      for (int p = 0; p < ITER; p++) begin
        p_dly[p]  = int'($urandom_range(1, 8));
        p_hold[p] = int'($urandom_range(1, 4));
        p_rslt[p] = (r % 3 == 0) ? 1'b1 : ($urandom_range(0, 5) != 0);
        if (p_rslt[p]) ep++;
      end
      do_run(1'(r % 2), ep, ITER - ep, (ep == ITER), (ep != ITER), $sformatf("rnd%0d", r));
    end

`ifdef WATCHDOG_TIMEOUT_EN
    // Tester never answers pass 2: abort to REPORT after 8 WAIT cycles
    begin
      int base;
      base  = run_pulses;
      Start = 1'b1;
      tick();
      chk("wd_start", 32'(ChipRun), 32'd1);
      Start = 1'b0;
      do_pass(3, 1, 1'b1, 1'b0);
      chk("wd_run2", 32'(ChipRun), 32'd1);
      tick();
      repeat (7) tick();
      chk("wd_early", 32'(DispRslt), 32'd0);
      tick();
      chk("wd_disp", 32'(DispRslt), 32'd1);
      chk("wd_timeout", 32'(Timeout), 32'd1);
      chk("wd_counts", 32'({PassCnt, FailCnt}), 32'({8'd1, 8'd1}));
      chk("wd_verdict", 32'({Pass, Fail}), 32'b01);
      repeat (3) tick();
      chk("wd_pulses", 32'(run_pulses - base), 32'd2);
    end
    for (int p = 0; p < ITER; p++) begin
      p_dly[p] = 8; p_hold[p] = 1; p_rslt[p] = 1'b1;
    end
    do_run(1'b0, ITER, 0, 1'b1, 1'b0, "wd_rerun");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
